// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, widths and range helper for the APB completer memory
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_cmp_state_t;

    localparam int APB_ADDR_WIDTH = 10;
    localparam int APB_DATA_WIDTH = 16;

    // Full-width compare also rejects any address bit set above the array index
    function automatic logic apb_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - DEPTH x DATA_WIDTH word array, async clear, 1R/1W with byte enables
module apb_mem_array #(
    parameter int DEPTH      = 384,
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AW-1:0]           rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = (32'(rd_addr) < 32'(DEPTH)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/apb_completer_mem.sv
// rtl/apb_completer_mem.sv - APB3 completer memory with wait states and PSLVERR; APB_PSTRB_EN adds byte strobes
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int DEPTH       = 384,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int LAW   = $clog2(DEPTH);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    apb_cmp_state_t        state;
    logic [CNT_W-1:0]      cnt;
    logic                  in_range;
    logic                  wr_en;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] resp_data;

    assign in_range  = apb_in_range(32'(PADDR), 32'(DEPTH));
    assign wr_en     = (state == ACCESS) && PSEL && PENABLE && PREADY && PWRITE && in_range;
    assign resp_data = (!PWRITE && in_range) ? rd_data : '0;

`ifdef APB_PSTRB_EN
    assign be = PSTRB;
`else
    assign be = '1;
`endif

    apb_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (LAW)
    ) u_mem (
        .clk     (PCLK),
        .rst     (PRESET),
        .rd_addr (PADDR[LAW-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (PADDR[LAW-1:0]),
        .wr_be   (be),
        .wr_data (PWDATA)
    );

    // Response registers load on the edge that raises PREADY, so data and error arrive together
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state <= ACCESS;
                        cnt   <= CNT_W'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= !in_range;
                            PRDATA  <= resp_data;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSEL || (PENABLE && PREADY)) begin
                        state   <= IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end else if (PENABLE) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= !in_range;
                            PRDATA  <= resp_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_completer_mem.sv
// tb/tb_apb_completer_mem.sv - randomized bench against a word-array model; instance 0 WAIT=2, instance 1 WAIT=0
module tb_apb_completer_mem;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 384;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    logic          psel    [2];
    logic          penable [2];
    logic          pwrite  [2];
    logic [AW-1:0] paddr   [2];
    logic [DW-1:0] pwdata  [2];
    logic [NB-1:0] pstrb   [2];
    logic [DW-1:0] prdata  [2];
    logic          pready  [2];
    logic          pslverr [2];

    logic [DW-1:0] mdl [2][DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    apb_completer_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb[0]),
`endif
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_completer_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb[1]),
`endif
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
    endtask

    task automatic bus_idle();
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
    endtask

    // Called #1 after an edge; returns #1 after the completing edge with the bus released
    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [NB-1:0] st, output logic [DW-1:0] rd, output logic err, output int cyc);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        cyc = 1;
        while (!pready[d] && cyc < 32) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge PCLK); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic do_check(input int d, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [NB-1:0] st, input string tag);
        logic [DW-1:0] rd, exp_rd;
        logic [NB-1:0] eff;
        logic          err;
        int            cyc;
        bit            in;
        in     = (int'(a) < DEPTH);
        exp_rd = (!wr && in) ? mdl[d][a] : '0;
`ifdef APB_PSTRB_EN
        eff = st;
`else
        eff = '1;
`endif
        xfer(d, wr, a, wd, st, rd, err, cyc);
        if (wr && in)
            for (int b = 0; b < NB; b++)
                if (eff[b]) mdl[d][a][b*8 +: 8] = wd[b*8 +: 8];
        check_eq({tag, ".cycles"}, cyc, wait_of(d) + 1);
        check_eq({tag, ".pslverr"}, err, !in);
        if (!wr) check_eq({tag, ".prdata"}, rd, exp_rd);
        check_eq({tag, ".pready_after"}, pready[d], 1'b0);
    endtask

    initial begin
        bus_idle();
        model_clear();
        PRESET = 1'b1;
        psel[0] = 1'b1; penable[0] = 1'b1;
        @(posedge PCLK); #1;
        check_eq("rst.pready", pready[0], 1'b0);
        check_eq("rst.pslverr", pslverr[0], 1'b0);
        check_eq("rst.prdata", prdata[0], 16'h0000);
        PRESET = 1'b0;
        bus_idle();
        @(posedge PCLK); #1;
        do_check(0, 1'b0, 10'h000, '0, '0, "rst_read0");

        // Lone PENABLE with no setup must be ignored
        psel[0] = 1'b1; penable[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            check_eq("noset.pready", pready[0], 1'b0);
        end
        bus_idle();
        @(posedge PCLK); #1;

        do_check(0, 1'b1, 10'h001, 16'hBB22, '1, "wr1");
        do_check(0, 1'b0, 10'h001, '0, '0, "rd1");
        check_eq("rd1.model", mdl[0][1], 16'hBB22);
        do_check(0, 1'b1, 10'h17F, 16'hBB55, '1, "wr_last");
        do_check(0, 1'b0, 10'h17F, '0, '0, "rd_last");
        do_check(0, 1'b1, 10'h180, 16'h1234, '1, "wr_oor");
        do_check(0, 1'b0, 10'h180, '0, '0, "rd_oor");
        do_check(0, 1'b1, 10'h200, 16'h5A5A, '1, "wr_hibit");
        do_check(0, 1'b0, 10'h200, '0, '0, "rd_hibit");
        do_check(0, 1'b0, 10'h000, '0, '0, "rd_alias0");

        for (int d = 0; d < 2; d++) begin
            do_check(d, 1'b1, 10'h002, 16'hBB33, '1, "b2b_wr");
            do_check(d, 1'b0, 10'h002, '0, '0, "b2b_rd");
        end

        // Reset in access cycle 2 and, more strongly, in cycle 3 where PREADY is high
        for (int k = 2; k <= 3; k++) begin
            psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h003;
            pwdata[0] = 16'hAAAA; pstrb[0] = '1;
            @(posedge PCLK); #1;
            penable[0] = 1'b1;
            for (int c = 1; c < k; c++) begin
                @(posedge PCLK); #1;
            end
            PRESET = 1'b1;
            #1;
            check_eq("midrst.pready", pready[0], 1'b0);
            check_eq("midrst.prdata", prdata[0], 16'h0000);
            model_clear();
            bus_idle();
            @(posedge PCLK); #1;
            PRESET = 1'b0;
            @(posedge PCLK); #1;
            do_check(0, 1'b0, 10'h003, '0, '0, "midrst_rd");
        end

`ifdef APB_PSTRB_EN
        do_check(0, 1'b1, 10'h004, 16'hBB44, 2'b11, "strb_init");
        do_check(0, 1'b1, 10'h004, 16'h1122, 2'b01, "strb_lo");
        do_check(0, 1'b0, 10'h004, '0, '0, "strb_lo_rd");
        check_eq("strb_lo.model", mdl[0][4], 16'hBB22);
        do_check(0, 1'b1, 10'h004, 16'hFFFF, 2'b00, "strb_none");
        do_check(0, 1'b0, 10'h004, '0, '0, "strb_none_rd");
`endif

        for (int i = 0; i < 120; i++) begin
            int            d;
            logic [AW-1:0] a;
            d = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = AW'($urandom);
                1:       a = AW'($urandom_range(0, 15));
                default: a = AW'($urandom_range(0, DEPTH - 1));
            endcase
            do_check(d, 1'($urandom), a, DW'($urandom), NB'($urandom), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge PCLK); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
